// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared state encoding, default sizes and bus-width helpers for the register file
package regfile_mp_pkg;
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} rf_state_e;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD = 2;
  function automatic int rbus_w(input int nrd, input int data_w);
    return nrd * data_w;
  endfunction
  function automatic int abus_w(input int nrd, input int addr_w);
    return nrd * addr_w;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: register file bus (clear request, write port, NRD packed read ports, status)
// master drives clr/wr_*/rd_en/rd_addr and observes wr_drop/rd_data/busy; slave is the register file
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD = DEF_NRD
);
  logic clr;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic wr_drop;
  logic [NRD-1:0] rd_en;
  logic [abus_w(NRD, ADDR_W)-1:0] rd_addr;
  logic [rbus_w(NRD, DATA_W)-1:0] rd_data;
  logic busy;
  modport master (output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr, input wr_drop, rd_data, busy);
  modport slave (input clr, wr_en, wr_addr, wr_data, rd_en, rd_addr, output wr_drop, rd_data, busy);
endinterface

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: CLEAR/READY sequencer that sweeps zeroes through the array and flags dropped writes
// ports: clk_i, rst_ni (async low), clr_i, wr_en_i in; busy_o, wr_drop_o, clr_we_o, clr_addr_o out
module regfile_clr_fsm
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wr_en_i,
  output logic              busy_o,
  output logic              wr_drop_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);
  rf_state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic drop_q, drop_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
    end
  end
  // clr has priority so a request on the final sweep cycle still restarts the sweep
  always_comb begin
    state_d = clr_i ? CLEAR : (state_q == CLEAR && cnt_q == '1) ? READY : state_q;
    cnt_d = clr_i ? '0 : (state_q == CLEAR) ? cnt_q + 1'b1 : cnt_q;
    drop_d = (state_q == CLEAR) && wr_en_i;
  end
  always_comb begin
    busy_o = state_q == CLEAR;
    clr_we_o = state_q == CLEAR;
    clr_addr_o = cnt_q;
    wr_drop_o = drop_q;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 1-write / NRD-read register file with registered reads, write-first bypass and zero-clear sweep
// ports: clk, rst_n (async low), bus (regfile_mp_if.slave: clr, wr_*, rd_en, rd_addr in; wr_drop, rd_data, busy out)
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD = DEF_NRD,
  parameter bit ZERO_REG = 1'b1
) (
  input logic clk,
  input logic rst_n,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic busy, clr_we;
  logic [ADDR_W-1:0] clr_addr, rd_a;
  logic wr_ok;
  logic [rbus_w(NRD, DATA_W)-1:0] rd_q, rd_d;
  regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk_i(clk),
    .rst_ni(rst_n),
    .clr_i(bus.clr),
    .wr_en_i(bus.wr_en),
    .busy_o(busy),
    .wr_drop_o(bus.wr_drop),
    .clr_we_o(clr_we),
    .clr_addr_o(clr_addr)
  );
  assign wr_ok = bus.wr_en && !busy && !(ZERO_REG && bus.wr_addr == '0);
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= '0;
    else if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
  end
  // wr_ok already excludes busy and the hardwired zero register, so it also gates the bypass
  always_comb begin
    rd_d = rd_q;
    rd_a = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_a = bus.rd_addr[p*ADDR_W +: ADDR_W];
      if (bus.rd_en[p])
        rd_d[p*DATA_W +: DATA_W] = (busy || (ZERO_REG && rd_a == '0)) ? '0 :
                                   (wr_ok && rd_a == bus.wr_addr) ? bus.wr_data : mem[rd_a];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else rd_q <= rd_d;
  end
  assign bus.rd_data = rd_q;
  assign bus.busy = busy;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against a sweep-countdown reference model
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus ();
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // model: sweep_left counts remaining busy cycles; the array is simply zeroed when a sweep begins
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] exp_rd [NR];
  int sweep_left;
  logic exp_drop;
  function automatic logic [DW-1:0] rdp(input int p);
    return bus.rd_data[p*DW +: DW];
  endfunction
  task automatic model_reset();
    sweep_left = DEPTH;
    exp_drop = 1'b0;
    foreach (m_mem[k]) m_mem[k] = '0;
    foreach (exp_rd[k]) exp_rd[k] = '0;
  endtask
  task automatic idle();
    bus.clr = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en = '0;
    bus.rd_addr = '0;
  endtask
  task automatic rd(input int p, input int a);
    bus.rd_en[p] = 1'b1;
    bus.rd_addr[p*AW +: AW] = AW'(a);
  endtask
  task automatic wr(input int a, input logic [DW-1:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
  endtask
  task automatic tick();
    bit b;
    int a;
    b = sweep_left > 0;
    exp_drop = b && bus.wr_en;
    for (int p = 0; p < NR; p++) begin
      a = int'(bus.rd_addr[p*AW +: AW]);
      if (bus.rd_en[p])
        exp_rd[p] = (b || a == 0) ? '0 : (bus.wr_en && a == int'(bus.wr_addr)) ? bus.wr_data : m_mem[a];
    end
    if (!b && bus.wr_en && bus.wr_addr != '0) m_mem[bus.wr_addr] = bus.wr_data;
    if (bus.clr) begin
      sweep_left = DEPTH;
      foreach (m_mem[k]) m_mem[k] = '0;
    end else if (sweep_left > 0) sweep_left--;
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic count_busy(input string nm);
    int n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d want %0d", nm, n, DEPTH);
    end
  endtask
  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if (bus.busy !== 1'b1 || bus.wr_drop !== 1'b0 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL reset busy=%b drop=%b rd=%h want 1 0 0", bus.busy, bus.wr_drop, bus.rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("reset_sweep");
    for (int a = 0; a < DEPTH; a += 2) begin
      rd(0, a);
      rd(1, a + 1);
      tick();
      checks++;
      if (rdp(0) !== 32'h0 || rdp(1) !== 32'h0) begin
        errors++;
        $display("FAIL clear_read addr %0d got %h %h want 0 0", a, rdp(0), rdp(1));
      end
    end
  endtask
  task automatic test_bypass();
    wr(3, 32'hDEADBEEF);
    rd(0, 3);
    tick();
    checks++;
    if (rdp(0) !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass port0 got %h want deadbeef", rdp(0));
    end
    rd(1, 3);
    tick();
    checks++;
    if (rdp(1) !== 32'hDEADBEEF || rdp(0) !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL stored port1 got %h port0 %h want deadbeef deadbeef", rdp(1), rdp(0));
    end
  endtask
  task automatic test_zero_reg();
    wr(0, 32'h00001234);
    rd(0, 0);
    rd(1, 0);
    tick();
    checks++;
    if (rdp(0) !== 32'h0 || rdp(1) !== 32'h0) begin
      errors++;
      $display("FAIL zero_bypass got %h %h want 0 0", rdp(0), rdp(1));
    end
    rd(0, 3);
    rd(1, 3);
    tick();
    rd(0, 0);
    rd(1, 0);
    tick();
    checks++;
    if (rdp(0) !== 32'h0 || rdp(1) !== 32'h0) begin
      errors++;
      $display("FAIL zero_read got %h %h want 0 0", rdp(0), rdp(1));
    end
  endtask
  task automatic test_drop();
    wr(7, 32'hA5A5A5A5);
    tick();
    bus.clr = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) tick();
    wr(7, $urandom());
    tick();
    checks++;
    if (bus.wr_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse got %b want 1", bus.wr_drop);
    end
    tick();
    checks++;
    if (bus.wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_len got %b want 0", bus.wr_drop);
    end
    for (int k = 0; k < 40 && bus.busy === 1'b1; k++) tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_ready busy got %b want 0", bus.busy);
    end
    rd(1, 7);
    tick();
    checks++;
    if (rdp(1) !== exp_rd[1] || rdp(1) !== 32'h0) begin
      errors++;
      $display("FAIL drop_read got %h want 0", rdp(1));
    end
  endtask
  task automatic test_hold();
    logic [DW-1:0] h0, h1;
    wr(12, $urandom());
    tick();
    rd(0, 12);
    rd(1, 3);
    tick();
    h0 = exp_rd[0];
    h1 = exp_rd[1];
    for (int k = 0; k < 6; k++) begin
      bus.rd_addr = AW*NR'($urandom());
      wr(int'(bus.rd_addr[AW-1:0]), $urandom());
      tick();
      checks++;
      if (rdp(0) !== h0 || rdp(1) !== h1) begin
        errors++;
        $display("FAIL hold got %h %h want %h %h", rdp(0), rdp(1), h0, h1);
      end
    end
  endtask
  task automatic test_reset_mid();
    bus.clr = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) tick();
    rst_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if (bus.busy !== 1'b1 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL mid_reset busy=%b rd=%h want 1 0", bus.busy, bus.rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("mid_reset_sweep");
    wr(9, 32'h55);
    tick();
    rd(0, 9);
    tick();
    checks++;
    if (rdp(0) !== 32'h55) begin
      errors++;
      $display("FAIL pre_clr got %h want 55", rdp(0));
    end
    bus.clr = 1'b1;
    tick();
    count_busy("clr_sweep");
    rd(0, 9);
    tick();
    checks++;
    if (rdp(0) !== 32'h0) begin
      errors++;
      $display("FAIL post_clr got %h want 0", rdp(0));
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.clr = $urandom_range(0, 79) == 0;
      if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 7), $urandom());
      bus.rd_en = NR'($urandom());
      for (int p = 0; p < NR; p++) bus.rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      tick();
      checks++;
      if (bus.busy !== (sweep_left > 0) || bus.wr_drop !== exp_drop || rdp(0) !== exp_rd[0] || rdp(1) !== exp_rd[1]) begin
        errors++;
        $display("FAIL random cyc %0d busy=%b drop=%b rd=%h %h want %b %b %h %h", n, bus.busy, bus.wr_drop,
                 rdp(0), rdp(1), sweep_left > 0, exp_drop, exp_rd[0], exp_rd[1]);
      end
    end
  endtask
  initial begin
    idle();
    #1;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_drop();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
